// File: rtl/fir_output_capture.sv
// Capture buffer for the FIR y_out stream: stores a programmed number of samples,
// tracks their peak magnitude, then replays them over a valid/ready read port.
module fir_output_capture #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 256,
   parameter int SKIP  = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       y_in,
   input  logic                   y_valid,
   input  logic                   arm,
   input  logic [$clog2(DEPTH):0] len,
   input  logic                   abort,
   input  logic                   rd_ready,
   output logic                   rd_valid,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   rd_last,
   output logic                   busy,
   output logic                   done,
   output logic [WIDTH-1:0]       peak,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = (SKIP > 1) ? $clog2(SKIP) : 1;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SKIP     = 3'd1;
   localparam logic [2:0] ST_CAPTURE  = 3'd2;
   localparam logic [2:0] ST_PREFETCH = 3'd3;
   localparam logic [2:0] ST_READOUT  = 3'd4;

   localparam logic [AW:0]      DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [2:0]       state_reg;
   logic [AW:0]      len_eff_reg;
   logic [AW:0]      count_reg;
   logic [WIDTH-1:0] peak_reg;
   logic [SW-1:0]    skip_cnt_reg;
   logic [AW-1:0]    rd_addr_reg;
   logic             rd_valid_reg;
   logic             rd_last_reg;
   logic             done_reg;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] ram_q;
   logic [WIDTH-1:0] mag;
   logic [AW:0]      len_eff_next;
   logic [AW-1:0]    rd_addr_next;
   logic             rd_en;
   logic             wr_en;
   logic             rd_hs;

   // Most negative input has no positive twin, so it saturates.
   always_comb begin
      mag = y_in;
      if (y_in[WIDTH-1]) begin
         mag = (y_in == MIN_NEG) ? MAX_POS : -y_in;
      end
   end

   assign len_eff_next = (len == '0 || len > DEPTH_L) ? DEPTH_L : len;
   assign rd_hs        = rd_valid_reg && rd_ready;
   assign wr_en        = (state_reg == ST_CAPTURE) && y_valid && !abort;

   always_comb begin
      rd_en        = 1'b0;
      rd_addr_next = rd_addr_reg;
      if (state_reg == ST_PREFETCH) begin
         rd_en        = 1'b1;
         rd_addr_next = '0;
      end else if (state_reg == ST_READOUT && rd_hs && !rd_last_reg) begin
         rd_en        = 1'b1;
         rd_addr_next = rd_addr_reg + AW'(1);
      end
   end

   // Storage and read register carry no reset so they map onto block RAM;
   // the write address is the low bits of the stored-sample count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[count_reg[AW-1:0]] <= y_in;
      end
      if (rd_en) begin
         ram_q <= mem[rd_addr_next];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= ST_IDLE;
         len_eff_reg  <= '0;
         count_reg    <= '0;
         peak_reg     <= '0;
         skip_cnt_reg <= '0;
         rd_addr_reg  <= '0;
         rd_valid_reg <= 1'b0;
         rd_last_reg  <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (abort) begin
            state_reg    <= ST_IDLE;
            rd_valid_reg <= 1'b0;
            rd_last_reg  <= 1'b0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (arm) begin
                     len_eff_reg  <= len_eff_next;
                     count_reg    <= '0;
                     peak_reg     <= '0;
                     skip_cnt_reg <= '0;
                     rd_addr_reg  <= '0;
                     state_reg    <= (SKIP > 0) ? ST_SKIP : ST_CAPTURE;
                  end
               end
               ST_SKIP: begin
                  if (y_valid) begin
                     if (int'(skip_cnt_reg) == SKIP - 1) begin
                        state_reg <= ST_CAPTURE;
                     end else begin
                        skip_cnt_reg <= skip_cnt_reg + SW'(1);
                     end
                  end
               end
               ST_CAPTURE: begin
                  if (y_valid) begin
                     count_reg <= count_reg + (AW+1)'(1);
                     if (mag > peak_reg) begin
                        peak_reg <= mag;
                     end
                     if (count_reg + (AW+1)'(1) == len_eff_reg) begin
                        state_reg <= ST_PREFETCH;
                     end
                  end
               end
               ST_PREFETCH: begin
                  rd_addr_reg  <= '0;
                  rd_valid_reg <= 1'b1;
                  rd_last_reg  <= (len_eff_reg == (AW+1)'(1));
                  state_reg    <= ST_READOUT;
               end
               ST_READOUT: begin
                  if (rd_hs) begin
                     if (rd_last_reg) begin
                        rd_valid_reg <= 1'b0;
                        rd_last_reg  <= 1'b0;
                        done_reg     <= 1'b1;
                        state_reg    <= ST_IDLE;
                     end else begin
                        rd_addr_reg <= rd_addr_next;
                        rd_last_reg <= ({1'b0, rd_addr_next} == len_eff_reg - (AW+1)'(1));
                     end
                  end
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

   assign rd_valid = rd_valid_reg;
   assign rd_data  = rd_valid_reg ? ram_q : '0;
   assign rd_last  = rd_last_reg;
   assign busy     = (state_reg != ST_IDLE);
   assign done     = done_reg;
   assign peak     = peak_reg;
   assign count    = count_reg;

endmodule
